// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, line levels and frame-length helper.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Frame length in bit periods: start + data + optional parity + stop.
    function automatic int frame_len(input int data_w, input bit parity);
        return data_w + 2 + (parity ? 1 : 0);
    endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit clock divider with 1-cycle bit_done pulse; held at 0 while disabled.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] r_cnt;
    assign o_bit_done = i_en && (r_cnt == CW'(CLKS_PER_BIT - 1));
    always_ff @(posedge clk) begin
        if (!rst || !i_en) r_cnt <= '0;
        else               r_cnt <= o_bit_done ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_sync_rstl.sv
// uart_tx_sync_rstl: UART transmitter, start/data(LSB first)/stop framing, sync active-low rst.
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_sync_rstl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);
    if (CLKS_PER_BIT < 2 || DATA_W < 5 || DATA_W > 9) begin : g_bad_param
        $error("uart_tx_sync_rstl: illegal CLKS_PER_BIT or DATA_W");
    end

    localparam int BW = $clog2(DATA_W);

    uart_state_e       r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_tx;
    logic              r_busy;
    logic              w_bit_done;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_busy),
        .o_bit_done (w_bit_done)
    );

    assign tx_ready = rst && (r_state == IDLE);
    assign tx       = r_tx;
    assign busy     = r_busy;

    // tx is registered, so each transition loads the level of the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= LINE_IDLE;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (tx_valid) begin
                    r_shreg  <= tx_data;
                    r_state  <= START;
                    r_tx     <= START_BIT;
                    r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                    r_parity <= ^tx_data;
`endif
                end
                START: if (w_bit_done) begin
                    r_state   <= DATA;
                    r_tx      <= r_shreg[0];
                    r_shreg   <= r_shreg >> 1;
                    r_bit_cnt <= '0;
                end
                DATA: if (w_bit_done) begin
                    if (r_bit_cnt == BW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= PARITY;
                        r_tx    <= r_parity;
`else
                        r_state <= STOP;
                        r_tx    <= STOP_BIT;
`endif
                    end else begin
                        r_tx      <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_bit_done) begin
                    r_state <= STOP;
                    r_tx    <= STOP_BIT;
                end
`endif
                STOP: if (w_bit_done) begin
                    r_state <= IDLE;
                    r_tx    <= LINE_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= LINE_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sync_rstl.sv
// tb_uart_tx_sync_rstl: directed frame checks at CLKS_PER_BIT=4, sampled on the falling edge.
// Parity expectations follow UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_tx_sync_rstl;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    int            n_cmp = 0;
    int            n_bad = 0;

    uart_tx_sync_rstl #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at the falling edge just after the accepting edge; checks every cycle of the frame.
    // lim=0 checks the whole frame plus the following idle cycle; pulse>0 pokes 0xFF at that cycle.
    task automatic observe(input logic [DW-1:0] d, input string tag, input int pulse, input int lim);
        int nb = frame_len(DW, PAR);
        int n  = (lim == 0) ? nb * CPB : lim;
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[1 + i] = d[i];
        if (PAR) f[1 + DW] = ^d;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s tx k=%0d", tag, k), int'(tx), int'(f[k / CPB]));
            chk($sformatf("%s busy k=%0d", tag, k), int'(busy), 1);
            chk($sformatf("%s ready k=%0d", tag, k), int'(tx_ready), 0);
            if (pulse > 0 && k == pulse) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (pulse > 0 && k == pulse + 2) tx_valid = 1'b0;
            @(negedge clk);
        end
        if (lim == 0) begin
            chk({tag, " end tx"}, int'(tx), 1);
            chk({tag, " end busy"}, int'(busy), 0);
            chk({tag, " end ready"}, int'(tx_ready), 1);
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst tx", int'(tx), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst ready", int'(tx_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post-rst ready", int'(tx_ready), 1);
        chk("post-rst tx", int'(tx), 1);

        send(8'hA5);
        tx_valid = 1'b0;
        observe(8'hA5, "a5", 0, 0);

        send(8'h01);
        tx_data = 8'h80;
        observe(8'h01, "b2b1", 0, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        observe(8'h80, "b2b2", 0, 0);

        send(8'h00);
        tx_valid = 1'b0;
        observe(8'h00, "ign", 4 * CPB + 1, 0);
        @(negedge clk);
        chk("ign after tx", int'(tx), 1);
        chk("ign after busy", int'(busy), 0);

        send(8'h3C);
        tx_valid = 1'b0;
        tx_data  = 8'hC3;
        observe(8'h3C, "hold", 0, 0);

        send(8'h55);
        tx_valid = 1'b0;
        observe(8'h55, "rst55", 0, 3 * CPB + 2);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst tx", int'(tx), 1);
        chk("midrst busy", int'(busy), 0);
        chk("midrst ready", int'(tx_ready), 0);
        @(negedge clk);
        chk("midrst hold tx", int'(tx), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rel ready", int'(tx_ready), 1);
        send(8'h55);
        tx_valid = 1'b0;
        observe(8'h55, "clean55", 0, 0);

        send(8'h07);
        tx_valid = 1'b0;
        observe(8'h07, "p07", 0, 0);
        send(8'h03);
        tx_valid = 1'b0;
        observe(8'h03, "p03", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
